dmem_line_responder: RTL and testbench
======================================

Name: dmem_line_responder

Overview:
- Memory-side responder for the data-memory request interface used by the pipelined CPU and its future data cache.
- Serves one 256-bit line read or write per request after a fixed, parameterised access latency.
- Returns completion with a one-cycle ack pulse.
- Sits behind the cache or CPU MEM stage. It is the stall source the hazard logic waits on.

Parameters:
- LINE_W, 256: line width in bits.
- DEPTH, 512: number of lines stored.
- LATENCY, 10: number of WAIT cycles per access; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  request valid; held high with fields stable until ack_o is seen
- we_i  in  1  1 = write line, 0 = read line
- addr_i  in  32  byte address; bits [4:0] ignored; index = addr_i[5 +: $clog2(DEPTH)]
- wdata_i  in  LINE_W  write line data
- ack_o  in/out: out  1  one-cycle completion pulse
- rdata_o  out  LINE_W  read line data, registered
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, counter 0, ack_o 0, busy_o 0, rdata_o 0. Storage array contents are not reset.
- States and transitions:
  - IDLE: when req_i=1, latch we_i, index and wdata_i; load cnt = LATENCY-1; go to WAIT.
  - WAIT: if cnt != 0, decrement. If cnt == 0, perform the access and go to ACK.
    - Write: array[index] <= latched wdata.
    - Read: rdata_o <= array[index].
  - ACK: ack_o=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: req_i high in IDLE cycle 0 gives WAIT in cycles 1..LATENCY and ack_o in cycle LATENCY+1. With LATENCY=10, ack_o is high in cycle 11.
- Handshake:
  - req_i is sampled only in IDLE.
  - req_i, we_i, addr_i and wdata_i changes during WAIT or ACK are ignored; fields are latched at accept.
  - The requester drops req_i in the cycle after ack_o. If req_i is still high in the following IDLE cycle, it is accepted as a new request.
  - Back-to-back throughput: one request per LATENCY+2 cycles.
- rdata_o:
  - Valid from the ACK cycle of a read.
  - Holds its value until the next read completes.
  - Writes never change it.
- Address wrap: index bits above $clog2(DEPTH) are discarded, so addresses alias modulo DEPTH*32 bytes.
- Reset mid-operation: reset during WAIT or ACK aborts the access. No array write occurs, rdata_o is cleared, and the state returns to IDLE. Reset has priority over every transition.
- Write followed by a read of the same index returns the new data; the write completes before the read is accepted.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output port err_o (1 bit, reset 0).
  - A request with any nonzero addr_i bit above the index field is out of range.
  - Out-of-range write: no array write.
  - Out-of-range read: rdata_o <= 0.
  - err_o=1 in the ACK cycle only; ack and latency timing are unchanged.
- Undefined: no err_o port; out-of-range addresses wrap as described in Behaviour.

Decomposition:
- Package dmem_pkg:
  - LINE_W default and OFFSET_BITS=5.
  - State enum {IDLE, WAIT, ACK}.
  - Counter width constant CNT_W=8.
- Sub-module dmem_line_array:
  - Synchronous single-port DEPTH x LINE_W storage.
  - Ports: clk_i, we, idx, wdata, rdata.
- The top level contains the FSM, counter and output registers.

Test Plan:
- Reset, then idle for 5 cycles -> ack_o=0, busy_o=0, rdata_o=0.
- Write addr 0x0000_0040 with data {8{32'hDEADBEEF}}, then read addr 0x0000_0040 -> ack_o in cycle 11 for each request; read rdata_o = {8{32'hDEADBEEF}}.
- Read addr 0x0000_0040 with bits [4:0]=5'h1F -> same line returned. Read addr 0x0000_4040 (DEPTH=512) -> aliases to index 2 (wrap, without DMEM_RANGE_CHECK_EN).
- Change addr_i and wdata_i during WAIT -> the latched address and data are used; busy_o=1 throughout cycles 1..11.
- Assert rst_i in cycle 5 of a write to index 3 -> no ack_o; a later read of index 3 returns its old contents; the state is IDLE the cycle after reset.
- With DMEM_RANGE_CHECK_EN defined: read addr 0x0000_4040 -> err_o=1 and ack_o=1 in cycle 11, rdata_o=0. Write to the same address -> index 2 is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and FSM state type for the data-memory line responder
package dmem_pkg;
    localparam int LINE_W_DEFAULT = 256;
    localparam int OFFSET_BITS    = 5;
    localparam int CNT_W          = 8;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: synchronous single-port DEPTH x LINE_W line storage with registered read
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int LINE_W = LINE_W_DEFAULT,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency line read/write responder with ack pulse; DMEM_RANGE_CHECK_EN adds err_o
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEFAULT,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] rdata_o,
    output logic              busy_o
`ifdef DMEM_RANGE_CHECK_EN
    ,output logic             err_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              oor_q, oor_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  addr_idx;
    logic              addr_oor;
    logic              done;
    logic              arr_we;
    logic [LINE_W-1:0] arr_rdata;
    logic              unused_addr;

    assign addr_idx    = addr_i[OFFSET_BITS +: IDX_W];
    assign unused_addr = ^{addr_i[OFFSET_BITS-1:0], addr_i[31:OFFSET_BITS+IDX_W]};
`ifdef DMEM_RANGE_CHECK_EN
    assign addr_oor = |addr_i[31:OFFSET_BITS+IDX_W];
`else
    assign addr_oor = 1'b0;
`endif
    assign done   = state_q == WAIT && cnt_q == '0;
    assign arr_we = done && we_q && !oor_q && !rst_i;

    // The array is addressed from the live request in IDLE so a read is ready even with LATENCY=1
    dmem_line_array #(.DEPTH(DEPTH), .LINE_W(LINE_W)) u_array (
        .clk_i (clk_i),
        .we    (arr_we),
        .idx   (state_q == IDLE ? addr_idx : idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
                we_d    = we_i;
                idx_d   = addr_idx;
                wdata_d = wdata_i;
                oor_d   = addr_oor;
            end
            WAIT: if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = ACK;
                ack_d   = 1'b1;
                rdata_d = we_q ? rdata_q : (oor_q ? '0 : arr_rdata);
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign err_d = done && oor_q;
    assign err_o = err_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            oor_q   <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            oor_q   <= oor_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ack_o   = ack_q;
    assign busy_o  = busy_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_line_responder.sv
// tb_dmem_line_responder: randomized self-checking bench with a line-level memory model
module tb_dmem_line_responder;
    localparam int LAT   = 10;
    localparam int DEPTH = 512;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
    logic err_o;
`else
    localparam bit RC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_i = 1'b0;
    logic         we_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] wdata_i = '0;
    logic         ack_o;
    logic [255:0] rdata_o;
    logic         busy_o;

    int checks = 0;
    int failures = 0;

    logic [255:0] mdl_mem [DEPTH];
    bit           mdl_known [DEPTH];
    logic [255:0] mdl_rdata = '0;
    bit           mdl_rv = 1'b1;

    always #5 clk = ~clk;

    dmem_line_responder #(.LINE_W(256), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .busy_o  (busy_o)
`ifdef DMEM_RANGE_CHECK_EN
        ,.err_o  (err_o)
`endif
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // One full transaction: latency, busy, data and the idle cycle after the ack are all checked
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [255:0] data, input bit scramble);
        int idx, n;
        bit oor, busy_ok, got_ack;
        idx = int'(addr[13:5]);
        oor = RC && (addr[31:14] != 0);
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = data;
        n = 0; busy_ok = 1'b1; got_ack = 1'b0;
        while (!got_ack && n < 4*LAT + 8) begin
            @(posedge clk); #1;
            n++;
            busy_ok = busy_ok && busy_o;
            if (ack_o) got_ack = 1'b1;
            else if (scramble) begin
                we_i = 1'($urandom_range(0, 1));
                addr_i = $urandom();
                wdata_i = rand_line();
            end
        end
        check("ack_latency", n, LAT + 1);
        check("busy_during_op", busy_ok, 1);
        if (we) begin
            if (!oor) begin
                mdl_mem[idx] = data;
                mdl_known[idx] = 1'b1;
            end
        end else begin
            mdl_rv = oor || mdl_known[idx];
            mdl_rdata = oor ? '0 : mdl_mem[idx];
        end
        if (mdl_rv) check(we ? "rdata_hold" : "rdata", rdata_o, mdl_rdata);
`ifdef DMEM_RANGE_CHECK_EN
        check("err_at_ack", err_o, oor);
`endif
        req_i = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", ack_o, 0);
        check("busy_after_ack", busy_o, 0);
`ifdef DMEM_RANGE_CHECK_EN
        check("err_one_cycle", err_o, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] a;
        int n;
        bit acked;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("reset_ack", ack_o, 0);
            check("reset_busy", busy_o, 0);
            check("reset_rdata", rdata_o, 0);
        end

        do_req(1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, 1'b0);
        do_req(1'b0, 32'h0000_0040, '0, 1'b0);
        check("deadbeef_read", rdata_o, {8{32'hDEADBEEF}});
        do_req(1'b0, 32'h0000_005F, '0, 1'b0);
        check("low_bits_ignored", rdata_o, {8{32'hDEADBEEF}});
        do_req(1'b0, 32'h0000_4040, '0, 1'b0);
        do_req(1'b1, 32'h0000_4040, rand_line(), 1'b0);
        do_req(1'b0, 32'h0000_0040, '0, 1'b0);

        do_req(1'b1, 32'h0000_0080, rand_line(), 1'b1);
        do_req(1'b0, 32'h0000_0080, '0, 1'b1);

        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i) << 5, rand_line(), 1'b0);

        // Reset in cycle 5 of a write to index 3 must leave the old line intact
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0060; wdata_i = rand_line();
        acked = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            acked = acked || ack_o;
        end
        rst_i = 1'b1; req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("rst_no_ack", acked, 0);
        check("rst_ack", ack_o, 0);
        check("rst_idle", busy_o, 0);
        check("rst_rdata", rdata_o, 0);
        mdl_rdata = '0; mdl_rv = 1'b1;
        do_req(1'b0, 32'h0000_0060, '0, 1'b0);

        // Back-to-back with req_i held: write then read of the same line
        a = rand_line();
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_00A0; wdata_i = a;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack_o && n < 100);
        check("b2b_first_latency", n, LAT + 1);
        we_i = 1'b0;
        mdl_mem[5] = a; mdl_known[5] = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack_o && n < 100);
        check("b2b_spacing", n, LAT + 2);
        check("b2b_read_new", rdata_o, a);
        req_i = 1'b0;
        mdl_rdata = a; mdl_rv = 1'b1;

        for (int k = 0; k < 60; k++) begin
            logic [31:0] ad;
            ad = {18'($urandom_range(0, 3) == 0 ? $urandom() : 0), 9'($urandom_range(0, 15)), 5'($urandom())};
            do_req(1'($urandom_range(0, 1)), ad, rand_line(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
